// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: the Memory stage passes straight through, and a debug/loader
// requester is served when the core is idle or forced in after MAX_WAIT refusals.
module dmem_arbiter #(
  parameter int WIDTH    = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             core_req,
  input  logic             core_we,
  input  logic [2:0]       core_mode,
  input  logic [WIDTH-1:0] core_addr,
  input  logic [WIDTH-1:0] core_wdata,
  output logic [WIDTH-1:0] core_rdata,
  output logic             core_stall,
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [2:0]       dbg_mode,
  input  logic [WIDTH-1:0] dbg_addr,
  input  logic [WIDTH-1:0] dbg_wdata,
  output logic [WIDTH-1:0] dbg_rdata,
  output logic             dbg_ack,
  output logic             mem_we,
  output logic [2:0]       mem_mode,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_e           state_q, state_d;
  logic [3:0]       wait_cnt_q, wait_cnt_d;
  logic             dbg_ack_q, dbg_ack_d;
  logic [WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;
  logic             starve;
  logic             grant_dbg;

  assign starve    = (wait_cnt_q == MAX_WAIT_C);
  // ACK blocks a grant so the core always wins the cycle after a forced stall.
  assign grant_dbg = dbg_req & (state_q != S_ACK) & (~core_req | starve);

  // Memory port steering between debug and core fields.
  always_comb begin
    mem_we    = 1'b0;
    mem_mode  = 3'd0;
    mem_addr  = {WIDTH{1'b0}};
    mem_wdata = {WIDTH{1'b0}};
    if (grant_dbg) begin
      mem_we    = dbg_we;
      mem_mode  = dbg_mode;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end else begin
      mem_we    = core_we & core_req;
      mem_mode  = core_mode;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end
  end

  assign core_stall = core_req & grant_dbg;
  assign core_rdata = mem_rdata;
  assign dbg_ack    = dbg_ack_q;
  assign dbg_rdata  = dbg_rdata_q;

  // Next-state, wait counter and debug response capture.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    dbg_ack_d   = grant_dbg;
    dbg_rdata_d = dbg_rdata_q;
    if (grant_dbg) begin
      dbg_rdata_d = mem_rdata;
    end else begin
      dbg_rdata_d = dbg_rdata_q;
    end
    case (state_q)
      S_IDLE: begin
        if (grant_dbg) begin
          state_d    = S_ACK;
          wait_cnt_d = 4'd0;
        end else if (dbg_req) begin
          state_d    = S_WAIT;
          wait_cnt_d = 4'd1;
        end else begin
          state_d    = S_IDLE;
          wait_cnt_d = 4'd0;
        end
      end
      S_WAIT: begin
        if (grant_dbg) begin
          state_d    = S_ACK;
          wait_cnt_d = 4'd0;
        end else if (dbg_req) begin
          state_d    = S_WAIT;
          wait_cnt_d = starve ? wait_cnt_q : (wait_cnt_q + 4'd1);
        end else begin
          // Requester withdrew without an ack: abandon the request silently.
          state_d    = S_IDLE;
          wait_cnt_d = 4'd0;
        end
      end
      S_ACK: begin
        state_d    = S_IDLE;
        wait_cnt_d = 4'd0;
      end
      default: begin
        state_d    = S_IDLE;
        wait_cnt_d = 4'd0;
      end
    endcase
  end

  // State and registered debug outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= 4'd0;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= {WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      dbg_ack_q   <= dbg_ack_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

endmodule
